// File: rtl/che_hist_pkg.sv
// Shared constants, derived widths and bank encoding for the CLAHE histogram bank.
package che_hist_pkg;

  function automatic int LOG2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int GRAY_WD     = 8;
  localparam int GRAY_LEVEAL = 1 << GRAY_WD;
  localparam int TILE_SIZ    = 32;
  localparam int SIZ_FRA_X   = 128;
  localparam int TILE_X_NUM  = SIZ_FRA_X / TILE_SIZ;
  localparam int TILE_IDX_WD = LOG2(TILE_X_NUM);
  localparam int CNT_WD      = LOG2(TILE_SIZ * TILE_SIZ) + 1;
  localparam int BANK_NUM    = 3;

  localparam logic [CNT_WD-1:0]  CNT_MAX  = '1;
  localparam logic [GRAY_WD-1:0] GRAY_MAX = '1;

  typedef enum logic [1:0] {
    BANK_0    = 2'd0,
    BANK_1    = 2'd1,
    BANK_2    = 2'd2,
    BANK_NONE = 2'd3
  } bank_e;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_CLR  = 2'd2;

  function automatic logic [CNT_WD-1:0] sat_inc(input logic [CNT_WD-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_WD'(1);
  endfunction

endpackage

// File: rtl/che_hist_mem.sv
// One histogram bank: per-tile bin counters with one write port, a clear-one-bin-in-all-tiles port
// and four combinational read ports.
module che_hist_mem
  import che_hist_pkg::*;
(
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [TILE_IDX_WD-1:0] wr_tile,
  input  logic [GRAY_WD-1:0]     wr_bin,
  input  logic [CNT_WD-1:0]      wr_data,
  output logic [CNT_WD-1:0]      wr_cur,
  input  logic                   clr_en,
  input  logic [GRAY_WD-1:0]     clr_bin,
  input  logic [TILE_IDX_WD-1:0] rd_tile_0,
  input  logic [GRAY_WD-1:0]     rd_bin_0,
  output logic [CNT_WD-1:0]      rd_cnt_0,
  input  logic [TILE_IDX_WD-1:0] rd_tile_1,
  input  logic [GRAY_WD-1:0]     rd_bin_1,
  output logic [CNT_WD-1:0]      rd_cnt_1,
  input  logic [TILE_IDX_WD-1:0] rd_tile_2,
  input  logic [GRAY_WD-1:0]     rd_bin_2,
  output logic [CNT_WD-1:0]      rd_cnt_2,
  input  logic [TILE_IDX_WD-1:0] rd_tile_3,
  input  logic [GRAY_WD-1:0]     rd_bin_3,
  output logic [CNT_WD-1:0]      rd_cnt_3
);

  logic [CNT_WD-1:0] cnt [TILE_X_NUM][GRAY_LEVEAL];

  // Contents are initialised by the clear sweep, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (wr_en && !(clr_en && (wr_bin == clr_bin))) begin
      cnt[wr_tile][wr_bin] <= wr_data;
    end
    if (clr_en) begin
      for (int t = 0; t < TILE_X_NUM; t++) begin
        cnt[t[TILE_IDX_WD-1:0]][clr_bin] <= '0;
      end
    end
  end

  assign wr_cur   = cnt[wr_tile][wr_bin];
  assign rd_cnt_0 = cnt[rd_tile_0][rd_bin_0];
  assign rd_cnt_1 = cnt[rd_tile_1][rd_bin_1];
  assign rd_cnt_2 = cnt[rd_tile_2][rd_bin_2];
  assign rd_cnt_3 = cnt[rd_tile_3][rd_bin_3];

endmodule

// File: rtl/che_hist_bank.sv
// Three rotating histogram banks: increment RMW pipeline, two registered read ports,
// bank clear sweep and sticky protocol error flag.
//
// state   | meaning
// INIT    | post-reset sweep, clears every bank one bin per cycle
// IDLE    | no sweep, clear pulses accepted
// CLR     | sweeping the latched bank one bin per cycle
module che_hist_bank
  import che_hist_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_hist_en_i,
  input  logic [1:0]             wr_hist_num_i,
  input  logic [TILE_IDX_WD-1:0] wr_hist_addr_i,
  input  logic [GRAY_WD-1:0]     wr_pix_i,
  input  logic                   rd_hist_en_a_i,
  input  logic [1:0]             rd_hist_num_a_i,
  input  logic [TILE_IDX_WD-1:0] rd_hist_addr_a_i,
  input  logic                   rd_hist_double_flg_a_i,
  input  logic [GRAY_WD-1:0]     rd_bin_a_i,
  input  logic                   rd_hist_en_b_i,
  input  logic [1:0]             rd_hist_num_b_i,
  input  logic [TILE_IDX_WD-1:0] rd_hist_addr_b_i,
  input  logic                   rd_hist_double_flg_b_i,
  input  logic [GRAY_WD-1:0]     rd_bin_b_i,
  input  logic                   cl_hist_en_c_i,
  input  logic [1:0]             cl_hist_num_c_i,
  output logic                   rd_vld_a_o,
  output logic [CNT_WD-1:0]      rd_cnt_a_o,
  output logic [CNT_WD-1:0]      rd_cnt_a_nxt_o,
  output logic                   rd_vld_b_o,
  output logic [CNT_WD-1:0]      rd_cnt_b_o,
  output logic [CNT_WD-1:0]      rd_cnt_b_nxt_o,
  output logic                   cl_busy_o,
  output logic                   err_o
);

  logic [1:0]         state, state_nxt;
  logic [GRAY_WD-1:0] ptr, ptr_nxt;
  logic [1:0]         clr_bank, clr_bank_nxt;
  logic [3:0]         bank_clr;
  logic               sweep_all, sweep_one;

  logic               wr_acc, rd_acc_a, rd_acc_b, cl_acc, err_set;

  logic                   s1_vld;
  logic [1:0]             s1_bank;
  logic [TILE_IDX_WD-1:0] s1_tile;
  logic [GRAY_WD-1:0]     s1_bin;
  logic                   s2_we;
  logic [CNT_WD-1:0]      s2_data;

  logic [TILE_IDX_WD-1:0] ta_n, tb_n;
  logic                   fwd_a, fwd_an, fwd_b, fwd_bn;

  logic [CNT_WD-1:0] cur  [4];
  logic [CNT_WD-1:0] ra   [4];
  logic [CNT_WD-1:0] ran  [4];
  logic [CNT_WD-1:0] rb   [4];
  logic [CNT_WD-1:0] rbn  [4];

  assign sweep_all = (state == ST_INIT);
  assign sweep_one = (state == ST_CLR);
  assign bank_clr  = {1'b0,
                      sweep_all | (sweep_one && (clr_bank == BANK_2)),
                      sweep_all | (sweep_one && (clr_bank == BANK_1)),
                      sweep_all | (sweep_one && (clr_bank == BANK_0))};

  assign wr_acc   = wr_hist_en_i && (wr_hist_num_i != BANK_NONE) && !bank_clr[wr_hist_num_i];
  assign rd_acc_a = rd_hist_en_a_i && (rd_hist_num_a_i != BANK_NONE);
  assign rd_acc_b = rd_hist_en_b_i && (rd_hist_num_b_i != BANK_NONE);
  assign cl_acc   = cl_hist_en_c_i && (state == ST_IDLE) && (cl_hist_num_c_i != BANK_NONE);
  assign err_set  = (wr_hist_en_i && !wr_acc) || (rd_hist_en_a_i && !rd_acc_a) ||
                    (rd_hist_en_b_i && !rd_acc_b) || (cl_hist_en_c_i && !cl_acc);

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    clr_bank_nxt = clr_bank;
    case (state)
      ST_INIT, ST_CLR: begin
        ptr_nxt = ptr + GRAY_WD'(1);
        if (ptr == GRAY_MAX) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (cl_acc) begin
          state_nxt    = ST_CLR;
          clr_bank_nxt = cl_hist_num_c_i;
          ptr_nxt      = '0;
        end
      end
      default: begin
        state_nxt = ST_INIT;
        ptr_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_INIT;
      ptr       <= '0;
      clr_bank  <= '0;
      cl_busy_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      clr_bank  <= clr_bank_nxt;
      cl_busy_o <= (state_nxt != ST_IDLE);
      if (err_set) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld  <= 1'b0;
      s1_bank <= '0;
      s1_tile <= '0;
      s1_bin  <= '0;
    end else begin
      s1_vld <= wr_acc;
      if (wr_acc) begin
        s1_bank <= wr_hist_num_i;
        s1_tile <= wr_hist_addr_i;
        s1_bin  <= wr_pix_i;
      end
    end
  end

  // A bank that started sweeping after the request was accepted still ends up all-zero.
  assign s2_we   = s1_vld && !bank_clr[s1_bank];
  assign s2_data = sat_inc(cur[s1_bank]);

  for (genvar g = 0; g < BANK_NUM; g++) begin : g_bank
    che_hist_mem u_mem (
      .clk       (clk),
      .wr_en     (s2_we && (s1_bank == 2'(g))),
      .wr_tile   (s1_tile),
      .wr_bin    (s1_bin),
      .wr_data   (s2_data),
      .wr_cur    (cur[g]),
      .clr_en    (bank_clr[g]),
      .clr_bin   (ptr),
      .rd_tile_0 (rd_hist_addr_a_i),
      .rd_bin_0  (rd_bin_a_i),
      .rd_cnt_0  (ra[g]),
      .rd_tile_1 (ta_n),
      .rd_bin_1  (rd_bin_a_i),
      .rd_cnt_1  (ran[g]),
      .rd_tile_2 (rd_hist_addr_b_i),
      .rd_bin_2  (rd_bin_b_i),
      .rd_cnt_2  (rb[g]),
      .rd_tile_3 (tb_n),
      .rd_bin_3  (rd_bin_b_i),
      .rd_cnt_3  (rbn[g])
    );
  end

  assign cur[3] = '0;
  assign ra[3]  = '0;
  assign ran[3] = '0;
  assign rb[3]  = '0;
  assign rbn[3] = '0;

  // Without a usable neighbour the second read simply repeats the first address.
  assign ta_n = (rd_hist_double_flg_a_i && (rd_hist_addr_a_i != TILE_IDX_WD'(TILE_X_NUM - 1))) ?
                rd_hist_addr_a_i + TILE_IDX_WD'(1) : rd_hist_addr_a_i;
  assign tb_n = (rd_hist_double_flg_b_i && (rd_hist_addr_b_i != TILE_IDX_WD'(TILE_X_NUM - 1))) ?
                rd_hist_addr_b_i + TILE_IDX_WD'(1) : rd_hist_addr_b_i;

  assign fwd_a  = s2_we && (s1_bank == rd_hist_num_a_i) && (s1_tile == rd_hist_addr_a_i) &&
                  (s1_bin == rd_bin_a_i);
  assign fwd_an = s2_we && (s1_bank == rd_hist_num_a_i) && (s1_tile == ta_n) &&
                  (s1_bin == rd_bin_a_i);
  assign fwd_b  = s2_we && (s1_bank == rd_hist_num_b_i) && (s1_tile == rd_hist_addr_b_i) &&
                  (s1_bin == rd_bin_b_i);
  assign fwd_bn = s2_we && (s1_bank == rd_hist_num_b_i) && (s1_tile == tb_n) &&
                  (s1_bin == rd_bin_b_i);

  function automatic logic [CNT_WD-1:0] pick(input logic clr, input logic fwd,
                                             input logic [CNT_WD-1:0] fdata,
                                             input logic [CNT_WD-1:0] mdata);
    if (clr) return '0;
    if (fwd) return fdata;
    return mdata;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld_a_o     <= 1'b0;
      rd_cnt_a_o     <= '0;
      rd_cnt_a_nxt_o <= '0;
      rd_vld_b_o     <= 1'b0;
      rd_cnt_b_o     <= '0;
      rd_cnt_b_nxt_o <= '0;
    end else begin
      rd_vld_a_o <= rd_acc_a;
      rd_vld_b_o <= rd_acc_b;
      if (rd_acc_a) begin
        rd_cnt_a_o     <= pick(bank_clr[rd_hist_num_a_i], fwd_a, s2_data, ra[rd_hist_num_a_i]);
        rd_cnt_a_nxt_o <= pick(bank_clr[rd_hist_num_a_i], fwd_an, s2_data, ran[rd_hist_num_a_i]);
      end
      if (rd_acc_b) begin
        rd_cnt_b_o     <= pick(bank_clr[rd_hist_num_b_i], fwd_b, s2_data, rb[rd_hist_num_b_i]);
        rd_cnt_b_nxt_o <= pick(bank_clr[rd_hist_num_b_i], fwd_bn, s2_data, rbn[rd_hist_num_b_i]);
      end
    end
  end

endmodule
